// File: rtl/jal_redirect_ctrl_if.sv
// Decode/fetch bundle for the control-transfer redirect controller.
// master drives the instruction side, slave is the controller.
interface jal_redirect_ctrl_if;
  logic        iIR_VALID;
  logic [31:0] iIR;
  logic [31:0] iPC;
  logic [31:0] iRS1;
  logic        iBR_TAKEN;
  logic        iFETCH_READY;
  logic [31:0] oPC;
  logic        oREDIRECT;
  logic        oFLUSH;
  logic        oSTALL;
  logic [4:0]  oRD;
  logic [31:0] oREG_IN;
  logic        oRD_WE;
  logic        oMISALIGN;

  modport master (
    output iIR_VALID, iIR, iPC, iRS1, iBR_TAKEN, iFETCH_READY,
    input  oPC, oREDIRECT, oFLUSH, oSTALL,
    input  oRD, oREG_IN, oRD_WE, oMISALIGN
  );

  modport slave (
    input  iIR_VALID, iIR, iPC, iRS1, iBR_TAKEN, iFETCH_READY,
    output oPC, oREDIRECT, oFLUSH, oSTALL,
    output oRD, oREG_IN, oRD_WE, oMISALIGN
  );
endinterface

// File: rtl/jal_redirect_ctrl.sv
// JAL/JALR/taken-branch redirect sequencer: target + link,
// fetch handshake, then a fixed-length wrong-path flush.
module jal_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic iCLK,
  input logic iRST,
  jal_redirect_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REDIR = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_q, redir_d;
  logic        flush_q, flush_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] reg_in_q, reg_in_d;
  logic        rd_we_q, rd_we_d;
  logic        mis_q, mis_d;

  logic [31:0] ir;
  logic [31:0] j_imm, i_imm, b_imm;
  logic        is_jal, is_jalr, is_br;
  logic        take, link;
  logic [31:0] tgt;

  assign ir = bus.iIR;
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};
  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};

  assign is_jal  = (ir[6:0] == 7'h6F);
  assign is_jalr = (ir[6:0] == 7'h67) && (ir[14:12] == 3'd0);
  assign is_br   = (ir[6:0] == 7'h63);

  always_comb begin
    take = 1'b0;
    link = 1'b0;
    tgt  = '0;
    unique case (1'b1)
      is_jal: begin
        take = 1'b1;
        link = 1'b1;
        tgt  = bus.iPC + j_imm;
      end
      is_jalr: begin
        take = 1'b1;
        link = 1'b1;
        tgt  = (bus.iRS1 + i_imm) & ~32'h1;
      end
      is_br: begin
        take = bus.iBR_TAKEN;
        tgt  = bus.iPC + b_imm;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    reg_in_d = reg_in_q;
    rd_we_d  = 1'b0;
    mis_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iIR_VALID && take) begin
          if (tgt[1]) begin
            mis_d = 1'b1;
          end else begin
            pc_d    = tgt;
            redir_d = 1'b1;
            state_d = S_REDIR;
            if (link && (ir[11:7] != 5'd0)) begin
              rd_we_d  = 1'b1;
              rd_d     = ir[11:7];
              reg_in_d = bus.iPC + 32'd4;
            end
          end
        end
      end
      S_REDIR: begin
        if (bus.iFETCH_READY) begin
          redir_d = 1'b0;
          if (FLUSH_CYCLES != 0) begin
            state_d = S_FLUSH;
            flush_d = 1'b1;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          flush_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        redir_d = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      redir_q  <= 1'b0;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      reg_in_q <= '0;
      rd_we_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      reg_in_q <= reg_in_d;
      rd_we_q  <= rd_we_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.oPC       = pc_q;
  assign bus.oREDIRECT = redir_q;
  assign bus.oFLUSH    = flush_q;
  assign bus.oSTALL    = (state_q != S_IDLE);
  assign bus.oRD       = rd_q;
  assign bus.oREG_IN   = reg_in_q;
  assign bus.oRD_WE    = rd_we_q;
  assign bus.oMISALIGN = mis_q;
endmodule

// File: tb/tb_jal_redirect_ctrl.sv
// Bench for jal_redirect_ctrl: phase-based reference model checked
// every cycle, plus hand-computed directed expectations.
module tb_jal_redirect_ctrl;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jal_redirect_ctrl_if bus();

  jal_redirect_ctrl #(
    .RESET_PC(32'h0),
    .FLUSH_CYCLES(FC)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void ref_xfer(
    input logic [31:0] ir, pc, rs1, input logic tk,
    output logic take, output logic link, output logic [31:0] tgt);
    logic signed [20:0] jo;
    logic signed [11:0] io;
    logic signed [12:0] bo;
    int off;
    take = 1'b0;
    link = 1'b0;
    tgt  = 32'h0;
    if (ir[6:0] == 7'h6F) begin
      jo = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      off = jo;
      take = 1'b1;
      link = 1'b1;
      tgt = pc + 32'(off);
    end else if (ir[6:0] == 7'h67 && ir[14:12] == 3'd0) begin
      io = ir[31:20];
      off = io;
      take = 1'b1;
      link = 1'b1;
      tgt = (rs1 + 32'(off)) & 32'hFFFF_FFFE;
    end else if (ir[6:0] == 7'h63 && tk) begin
      bo = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      off = bo;
      take = 1'b1;
      tgt = pc + 32'(off);
    end
  endfunction

  // Model phases: waiting for fetch, then m_left flush cycles to go.
  bit          started = 0;
  bit          m_wait;
  int          m_left;
  logic [31:0] m_pc, m_reg;
  logic [4:0]  m_rd;
  logic        m_redir, m_we, m_mis;

  always @(posedge clk) begin
    logic tk_ok, lk;
    logic [31:0] t;
    if (rst) begin
      started = 1;
      m_wait = 0;
      m_left = 0;
      m_pc = 32'h0;
      m_reg = 32'h0;
      m_rd = 5'd0;
      m_redir = 0;
      m_we = 0;
      m_mis = 0;
    end else begin
      m_we = 0;
      m_mis = 0;
      if (m_left > 0) begin
        m_left--;
      end else if (m_wait) begin
        if (bus.iFETCH_READY) begin
          m_wait = 0;
          m_redir = 0;
          m_left = FC;
        end
      end else if (bus.iIR_VALID) begin
        ref_xfer(bus.iIR, bus.iPC, bus.iRS1, bus.iBR_TAKEN,
                 tk_ok, lk, t);
        if (tk_ok) begin
          if (t[1]) begin
            m_mis = 1;
          end else begin
            m_pc = t;
            m_redir = 1;
            m_wait = 1;
            if (lk && bus.iIR[11:7] != 5'd0) begin
              m_we = 1;
              m_rd = bus.iIR[11:7];
              m_reg = bus.iPC + 32'd4;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_pc", bus.oPC, m_pc);
      chk("m_redirect", 32'(bus.oREDIRECT), 32'(m_redir));
      chk("m_flush", 32'(bus.oFLUSH), 32'(m_left > 0));
      chk("m_stall", 32'(bus.oSTALL), 32'(m_wait || m_left > 0));
      chk("m_rd", 32'(bus.oRD), 32'(m_rd));
      chk("m_reg_in", bus.oREG_IN, m_reg);
      chk("m_rd_we", 32'(bus.oRD_WE), 32'(m_we));
      chk("m_misalign", 32'(bus.oMISALIGN), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, pc, rs1,
                       input logic tk, input logic rdy);
    bus.iIR_VALID = 1'b1;
    bus.iIR = ir;
    bus.iPC = pc;
    bus.iRS1 = rs1;
    bus.iBR_TAKEN = tk;
    bus.iFETCH_READY = rdy;
    step();
    bus.iIR_VALID = 1'b0;
  endtask

  initial begin
    bus.iIR_VALID = 1'b0;
    bus.iIR = 32'h0;
    bus.iPC = 32'h0;
    bus.iRS1 = 32'h0;
    bus.iBR_TAKEN = 1'b0;
    bus.iFETCH_READY = 1'b0;
    step();
    step();
    chk("rst_pc", bus.oPC, 32'h0);
    chk("rst_stall", 32'(bus.oSTALL), 32'h0);
    chk("rst_redirect", 32'(bus.oREDIRECT), 32'h0);
    rst = 1'b0;
    step();

    // jal x1, +32 at 0x100
    issue(32'h020000EF, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("jal_redirect", 32'(bus.oREDIRECT), 32'h1);
    chk("jal_pc", bus.oPC, 32'h120);
    chk("jal_we", 32'(bus.oRD_WE), 32'h1);
    chk("jal_rd", 32'(bus.oRD), 32'h1);
    chk("jal_link", bus.oREG_IN, 32'h104);
    chk("jal_stall", 32'(bus.oSTALL), 32'h1);
    step();
    chk("jal_flush1", 32'(bus.oFLUSH), 32'h1);
    chk("jal_redir_off", 32'(bus.oREDIRECT), 32'h0);
    chk("jal_we_off", 32'(bus.oRD_WE), 32'h0);
    step();
    chk("jal_flush2", 32'(bus.oFLUSH), 32'h1);
    step();
    chk("jal_flush_end", 32'(bus.oFLUSH), 32'h0);
    chk("jal_idle", 32'(bus.oSTALL), 32'h0);

    // beq x0,x0,-8 at 0x200, accepted in the first idle cycle
    issue(32'hFE000CE3, 32'h200, 32'h0, 1'b1, 1'b1);
    chk("br_pc", bus.oPC, 32'h1F8);
    chk("br_redirect", 32'(bus.oREDIRECT), 32'h1);
    chk("br_we", 32'(bus.oRD_WE), 32'h0);
    step();
    step();
    step();
    issue(32'hFE000CE3, 32'h200, 32'h0, 1'b0, 1'b1);
    chk("br_nt_redirect", 32'(bus.oREDIRECT), 32'h0);
    chk("br_nt_stall", 32'(bus.oSTALL), 32'h0);
    step();

    // fetch backpressure with an ignored pulse while stalled
    issue(32'h020000EF, 32'h400, 32'h0, 1'b0, 1'b0);
    chk("bp_pc1", bus.oPC, 32'h420);
    chk("bp_link", bus.oREG_IN, 32'h404);
    bus.iIR_VALID = 1'b1;
    bus.iPC = 32'h800;
    step();
    bus.iIR_VALID = 1'b0;
    chk("bp_pc2", bus.oPC, 32'h420);
    chk("bp_redir2", 32'(bus.oREDIRECT), 32'h1);
    step();
    chk("bp_redir3", 32'(bus.oREDIRECT), 32'h1);
    step();
    chk("bp_redir4", 32'(bus.oREDIRECT), 32'h1);
    chk("bp_noflush", 32'(bus.oFLUSH), 32'h0);
    bus.iFETCH_READY = 1'b1;
    step();
    bus.iFETCH_READY = 1'b0;
    chk("bp_flush", 32'(bus.oFLUSH), 32'h1);
    chk("bp_redir_off", 32'(bus.oREDIRECT), 32'h0);
    step();
    step();
    chk("bp_idle", 32'(bus.oSTALL), 32'h0);

    // jalr x0, 4(x5) with rs1 = 0x303 -> 0x306 misaligned
    issue(32'h00428067, 32'h0, 32'h303, 1'b0, 1'b1);
    chk("mis_pulse", 32'(bus.oMISALIGN), 32'h1);
    chk("mis_redirect", 32'(bus.oREDIRECT), 32'h0);
    chk("mis_stall", 32'(bus.oSTALL), 32'h0);
    chk("mis_we", 32'(bus.oRD_WE), 32'h0);
    step();
    chk("mis_end", 32'(bus.oMISALIGN), 32'h0);

    // jalr x0, 3(x5) with rs1 = 0x301 -> 0x304
    issue(32'h00328067, 32'h0, 32'h301, 1'b0, 1'b1);
    chk("jr_pc", bus.oPC, 32'h304);
    chk("jr_redirect", 32'(bus.oREDIRECT), 32'h1);
    chk("jr_we", 32'(bus.oRD_WE), 32'h0);
    step();
    step();
    step();
    chk("jr_idle", 32'(bus.oSTALL), 32'h0);

    // wrap-around target, then reset during the flush
    issue(32'h020000EF, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc", bus.oPC, 32'h10);
    chk("wrap_link", bus.oREG_IN, 32'hFFFF_FFF4);
    step();
    chk("wrap_flush", 32'(bus.oFLUSH), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_stall", 32'(bus.oSTALL), 32'h0);
    chk("rst2_flush", 32'(bus.oFLUSH), 32'h0);
    chk("rst2_redirect", 32'(bus.oREDIRECT), 32'h0);
    chk("rst2_pc", bus.oPC, 32'h0);
    chk("rst2_rd", 32'(bus.oRD), 32'h0);
    chk("rst2_link", bus.oREG_IN, 32'h0);
    chk("rst2_we", 32'(bus.oRD_WE), 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jal_redirect_ctrl.md
Name: jal_redirect_ctrl

Overview:
- Sequencing controller for control-transfer instructions (JAL, JALR, taken branches) in the RV32I core.
- Sits between decode and fetch. It decodes the J/B/I immediate, computes the redirect target and link value, and hands the target to fetch with a valid/ready handshake.
- It then flushes wrong-path instructions for a fixed number of cycles, stalling decode throughout.
- It replaces the ad-hoc "+8" PC compensation with an explicit, cycle-accurate redirect/flush sequence.

Parameters:
- RESET_PC, 32'h0000_0000: value of oPC after reset.
- FLUSH_CYCLES, 2: cycles oFLUSH is held after fetch accepts a redirect. Legal range 0..15.

Ports:
- iCLK  in  1  system clock; all logic on posedge.
- iRST  in  1  synchronous reset, active-high.
- iIR_VALID  in  1  iIR/iPC/iRS1/iBR_TAKEN valid this cycle.
- iIR  in  32  instruction word from decode.
- iPC  in  32  PC of iIR.
- iRS1  in  32  rs1 operand (used by JALR).
- iBR_TAKEN  in  1  branch compare result; meaningful only when opcode = 7'h63.
- iFETCH_READY  in  1  fetch accepts redirect.
- oPC  out  32  redirect target; valid while oREDIRECT = 1.
- oREDIRECT  out  1  redirect request to fetch.
- oFLUSH  out  1  kill in-flight fetched instructions.
- oSTALL  out  1  hold decode; new iIR is ignored.
- oRD  out  5  link destination register.
- oREG_IN  out  32  link value, iPC+4.
- oRD_WE  out  1  one-cycle link write strobe.
- oMISALIGN  out  1  one-cycle misaligned-target exception pulse.

Behaviour:
- **FSM states:** IDLE, REDIRECT, FLUSH. oSTALL = (state != IDLE), combinational from state.
- **Reset:** state = IDLE, oPC = RESET_PC, flush counter = 0. oREDIRECT, oFLUSH, oRD_WE and oMISALIGN = 0; oRD = 0; oREG_IN = 0. Reset wins over every other event and aborts any sequence in progress.
- **Acceptance:** an instruction is accepted only in IDLE with iIR_VALID = 1. Call the acceptance cycle T.
- **Opcode 7'h6F (JAL):**
  - imm = sign-extended {iIR[31], iIR[19:12], iIR[20], iIR[30:21], 1'b0}.
  - target = iPC + imm.
  - link write = yes.
- **Opcode 7'h67 (JALR, funct3 = 0):**
  - imm = sign-extended iIR[31:20].
  - target = (iRS1 + imm) & ~32'h1.
  - link write = yes.
- **Opcode 7'h63 with iBR_TAKEN = 1:**
  - imm = sign-extended {iIR[31], iIR[7], iIR[30:25], iIR[11:8], 1'b0}.
  - target = iPC + imm.
  - link write = no.
- **Any other opcode, or a branch not taken:** no action; state stays IDLE.
- **Arithmetic:** all additions are 32-bit modulo 2^32; wrap-around is silent.
- **Misaligned target (target[1] = 1):**
  - At T+1: oMISALIGN = 1 for one cycle.
  - No redirect and no link write; state stays IDLE.
- **Valid redirect, at T+1:**
  - oPC = target, oREDIRECT = 1, state = REDIRECT.
  - If link write and rd != 0: oRD_WE = 1 for exactly one cycle, with oRD = iIR[11:7] and oREG_IN = iPC + 4.
  - rd = 0 suppresses oRD_WE only; the redirect proceeds.
- **REDIRECT state:**
  - oREDIRECT and oPC are held stable until a cycle in which iFETCH_READY = 1. That cycle is the handshake.
  - iFETCH_READY may already be high at T+1; the handshake then completes at T+1.
- **Leaving REDIRECT, in the cycle after the handshake:**
  - oREDIRECT = 0.
  - If FLUSH_CYCLES > 0: state = FLUSH, oFLUSH = 1, counter = FLUSH_CYCLES - 1.
  - If FLUSH_CYCLES = 0: state = IDLE directly.
- **FLUSH state:**
  - oFLUSH stays high for exactly FLUSH_CYCLES cycles, then state returns to IDLE.
  - The counter decrements each cycle; exit when the counter = 0.
- **Back-to-back redirects:** a new instruction can be accepted in the first IDLE cycle. Minimum redirect-to-redirect spacing is 2 + FLUSH_CYCLES cycles.
- **Outside accepted control transfers:** oPC holds its last value. oRD and oREG_IN hold their last values when oRD_WE = 0.

Test Plan:
- **JAL with link:** iPC = 0x100, iIR = 0x020000EF (jal x1, +32), iFETCH_READY = 1.
  - T+1: oREDIRECT = 1, oPC = 0x120, oRD_WE = 1, oRD = 1, oREG_IN = 0x104.
  - T+2: oFLUSH = 1 and stays high for 2 cycles; oSTALL = 1 until IDLE.
- **Taken backward branch:** beq x0,x0,-8 at iPC = 0x200, iBR_TAKEN = 1.
  - oPC = 0x1F8, oRD_WE never asserts.
  - Same instruction with iBR_TAKEN = 0: no redirect and no stall.
- **Fetch backpressure:** JAL with iFETCH_READY held low for 3 cycles after T+1.
  - oREDIRECT and oPC stay stable for those 3 cycles.
  - oFLUSH starts the cycle after iFETCH_READY rises.
  - An iIR_VALID pulse during the stall is ignored.
- **JALR misaligned:** jalr x0, 4(x5) with iRS1 = 0x303.
  - Target 0x306 gives oMISALIGN = 1 for one cycle.
  - No oREDIRECT, no oRD_WE.
- **JALR aligned, rd = x0:** iRS1 = 0x301, imm = 3.
  - oPC = 0x304, oRD_WE = 0.
- **Wrap and reset:** JAL at iPC = 0xFFFF_FFF0 with imm +0x20 gives oPC = 0x0000_0010.
  - Assert iRST during FLUSH: next cycle state = IDLE, all strobes 0, oPC = RESET_PC.
